// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS data-memory controller.
//   dmem_state_t   : controller FSM states
//   DMEM_WORD_W    : data word width (bits)
//   DMEM_MMIO_BASE : default address of the memory-mapped output register
//   dmem_merge_be  : byte-lane merge of a new word into an old one
package mips_mem_pkg;

    localparam int unsigned DMEM_WORD_W    = 32;
    localparam int unsigned DMEM_LANES     = DMEM_WORD_W / 8;
    localparam logic [31:0] DMEM_MMIO_BASE = 32'hFFFF_FF00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } dmem_state_t;

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [DMEM_WORD_W-1:0] dmem_merge_be(
        input logic [DMEM_WORD_W-1:0] old_w,
        input logic [DMEM_WORD_W-1:0] new_w,
        input logic [DMEM_LANES-1:0]  be
    );
        logic [DMEM_WORD_W-1:0] res;
        res = old_w;
        for (int i = 0; i < int'(DMEM_LANES); i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-enable synchronous single-port RAM, DEPTH x 32, no reset.
//   clk   : clock, rising edge
//   en    : access enable (read or write)
//   we    : 1 = write enabled lanes, 0 = read word into rdata register
//   be    : byte-lane write enables
//   idx   : word index
//   wdata : write data
//   rdata : registered read data, updated only by reads
module dmem_array
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       en,
    input  logic                       we,
    input  logic [DMEM_LANES-1:0]      be,
    input  logic [$clog2(DEPTH)-1:0]   idx,
    input  logic [DMEM_WORD_W-1:0]     wdata,
    output logic [DMEM_WORD_W-1:0]     rdata
);

    logic [DMEM_WORD_W-1:0] mem_q [DEPTH];
    logic [DMEM_WORD_W-1:0] rdata_q;

    // Per-lane write keeps this a plain byte-write RAM for mapping.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < int'(DMEM_LANES); i++) begin
                    if (be[i]) begin
                        mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[idx];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mips_dmem_ctrl.sv
// Data-memory controller between the core load/store port and the data RAM.
// Request/ready handshake with programmable wait states, byte-lane stores
// and out-of-range error reporting. Optional memory-mapped output register
// is built when MIPS_DMEM_MMIO_EN is defined.
//   clk      : clock, rising edge
//   reset    : asynchronous active-low reset
//   req      : access request (held by the core until ready)
//   we       : 1 = store, 0 = load
//   be       : store byte enables
//   addr     : byte address (bits [1:0] ignored)
//   wdata    : store data
//   rdata    : load data, valid with ready (0 otherwise, and for stores/errors)
//   ready    : one-cycle completion pulse
//   err      : with ready, address was out of range
//   busy     : high from acceptance through the ready cycle
//   mmio_out : output register (MIPS_DMEM_MMIO_EN builds only)
module mips_dmem_ctrl
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] MMIO_BASE   = DMEM_MMIO_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
`ifdef MIPS_DMEM_MMIO_EN
    ,
    output logic [31:0] mmio_out
`endif
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 4;

    dmem_state_t            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic [3:0]             be_q, be_d;
    logic [31:2]            addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   ready_q, ready_d;
    logic                   err_q, err_d;
    logic                   busy_q, busy_d;
`ifdef MIPS_DMEM_MMIO_EN
    logic [31:0]            mmio_q, mmio_d;
`endif

    logic                   arr_en;
    logic                   arr_we;
    logic [31:0]            arr_rdata;

    // Address of the request being worked on: the live bus in IDLE,
    // the latched copy afterwards.
    logic [31:2]            cur_addr;
    logic                   cur_we;
    logic                   cur_ram;
    logic                   cur_mmio;
    logic                   q_ram;
    logic                   q_mmio;

    logic                   unused_addr_lsb;
    assign unused_addr_lsb = ^addr[1:0];

    assign cur_addr = (state_q == IDLE) ? addr[31:2] : addr_q;
    assign cur_we   = (state_q == IDLE) ? we : we_q;

`ifdef MIPS_DMEM_MMIO_EN
    assign cur_mmio = (cur_addr == MMIO_BASE[31:2]);
    assign q_mmio   = (addr_q == MMIO_BASE[31:2]);
`else
    logic unused_mmio_base;
    assign unused_mmio_base = ^MMIO_BASE;
    assign cur_mmio = 1'b0;
    assign q_mmio   = 1'b0;
`endif

    // MMIO decode wins over the RAM range check if they ever overlap.
    assign cur_ram = (cur_addr[31:IDX_W+2] == '0) && !cur_mmio;
    assign q_ram   = (addr_q[31:IDX_W+2] == '0) && !q_mmio;

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = '0;
        ready_d = 1'b0;
        err_d   = 1'b0;
`ifdef MIPS_DMEM_MMIO_EN
        mmio_d  = mmio_q;
`endif
        arr_en  = 1'b0;
        arr_we  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    be_d    = be;
                    addr_d  = addr[31:2];
                    wdata_d = wdata;
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_STATES - 1);
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACCESS: begin
                state_d = RESP;
                ready_d = 1'b1;
                err_d   = !q_ram && !q_mmio;
                if (we_q) begin
                    arr_en = q_ram;
                    arr_we = 1'b1;
`ifdef MIPS_DMEM_MMIO_EN
                    if (q_mmio) begin
                        mmio_d = dmem_merge_be(mmio_q, wdata_q, be_q);
                    end
`endif
                end else if (q_ram) begin
                    rdata_d = arr_rdata;
                end
`ifdef MIPS_DMEM_MMIO_EN
                else if (q_mmio) begin
                    rdata_d = mmio_q;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Loads read the RAM on the edge entering ACCESS so the word is
        // available to register into rdata on the edge leaving ACCESS.
        if (state_d == ACCESS && !cur_we && cur_ram) begin
            arr_en = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef MIPS_DMEM_MMIO_EN
            mmio_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
`ifdef MIPS_DMEM_MMIO_EN
            mmio_q  <= mmio_d;
`endif
        end
    end

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .en    (arr_en),
        .we    (arr_we),
        .be    (be_q),
        .idx   (cur_addr[IDX_W+1:2]),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign err   = err_q;
    assign busy  = busy_q;
`ifdef MIPS_DMEM_MMIO_EN
    assign mmio_out = mmio_q;
`endif

endmodule

// File: tb/tb_mips_dmem_ctrl.sv
// Scoreboard bench for mips_dmem_ctrl (WAIT_STATES=2 main instance plus a
// WAIT_STATES=0 instance for back-to-back throughput).
module tb_mips_dmem_ctrl;

    localparam int unsigned DEPTH     = 64;
    localparam int unsigned WS        = 2;
    localparam int unsigned TB_IDX_W  = $clog2(DEPTH);
    localparam logic [31:0] MMIO_BASE = 32'hFFFF_FF00;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        req, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata, rdata;
    logic        ready, err, busy;

    logic        req0, we0;
    logic [3:0]  be0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        ready0, err0, busy0;

`ifdef MIPS_DMEM_MMIO_EN
    logic [31:0] mmio_out, mmio_out0;
`endif

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_mmio;
    int          n_cmp;
    int          n_mis;

    mips_dmem_ctrl #(
        .DEPTH       (DEPTH),
        .WAIT_STATES (WS),
        .MMIO_BASE   (MMIO_BASE)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .we       (we),
        .be       (be),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .err      (err),
        .busy     (busy)
`ifdef MIPS_DMEM_MMIO_EN
        ,
        .mmio_out (mmio_out)
`endif
    );

    mips_dmem_ctrl #(
        .DEPTH       (DEPTH),
        .WAIT_STATES (0),
        .MMIO_BASE   (MMIO_BASE)
    ) u_dut0 (
        .clk      (clk),
        .reset    (reset),
        .req      (req0),
        .we       (we0),
        .be       (be0),
        .addr     (addr0),
        .wdata    (wdata0),
        .rdata    (rdata0),
        .ready    (ready0),
        .err      (err0),
        .busy     (busy0)
`ifdef MIPS_DMEM_MMIO_EN
        ,
        .mmio_out (mmio_out0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Pop one expectation per completion of the main instance.
    always @(negedge clk) begin
        if (reset && ready) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_ready", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("rdata", rdata, mon_e.rdata);
                check_eq("err", 32'(err), 32'(mon_e.err));
            end
        end
    end

    // Drive one access, push its expected response, wait for ready.
    task automatic do_access(input logic w, input logic [3:0] b,
                             input logic [31:0] a, input logic [31:0] d);
        exp_t        e;
        logic        in_rng, mm, ram, busy_ok;
        int unsigned wi;
        int          lat;
        @(negedge clk);
        check_eq("idle_busy", 32'(busy), 32'd0);
        req = 1'b1; we = w; be = b; addr = a; wdata = d;
        in_rng = ((a >> (TB_IDX_W + 2)) == 32'd0);
        mm = 1'b0;
`ifdef MIPS_DMEM_MMIO_EN
        mm = (a[31:2] == MMIO_BASE[31:2]);
`endif
        ram = in_rng && !mm;
        wi  = 32'(a[TB_IDX_W+1:2]);
        e.err = !ram && !mm;
        if (w) begin
            e.rdata = 32'd0;
            if (ram) begin
                for (int i = 0; i < 4; i++) begin
                    if (b[i]) model_mem[wi][8*i +: 8] = d[8*i +: 8];
                end
            end
            if (mm) begin
                for (int i = 0; i < 4; i++) begin
                    if (b[i]) model_mmio[8*i +: 8] = d[8*i +: 8];
                end
            end
        end else begin
            e.rdata = ram ? model_mem[wi] : (mm ? model_mmio : 32'd0);
        end
        exp_q.push_back(e);
        busy_ok = 1'b1;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (!busy) busy_ok = 1'b0;
            if (ready) begin
                lat = c;
                break;
            end
        end
        req = 1'b0;
        check_eq("latency", 32'(lat), 32'(WS + 2));
        check_eq("busy_held", 32'(busy_ok), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int pulses, last, first, extra;
        logic gap_ok, err_seen;
        n_cmp = 0; n_mis = 0;
        model_mmio = 32'd0;
        reset = 1'b0;
        req = 1'b0; we = 1'b0; be = 4'd0; addr = 32'd0; wdata = 32'd0;
        req0 = 1'b0; we0 = 1'b0; be0 = 4'd0; addr0 = 32'd0; wdata0 = 32'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 32'(ready), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
`ifdef MIPS_DMEM_MMIO_EN
        check_eq("rst_mmio", mmio_out, 32'd0);
`endif
        reset = 1'b1;

        // Initialise the low words so every later load has a known value.
        for (int i = 0; i < 10; i++) begin
            do_access(1'b1, 4'hF, 32'(i * 4), 32'hC0DE_0000 + 32'(i * 32'h111));
        end
        do_access(1'b0, 4'h0, 32'h0000_0000, 32'd0);

        do_access(1'b1, 4'hF,    32'h0000_0010, 32'hDEAD_BEEF);
        do_access(1'b1, 4'b0001, 32'h0000_0010, 32'h0000_00AA);
        do_access(1'b0, 4'h0,    32'h0000_0010, 32'd0);
        check_eq("merge_model", model_mem[4], 32'hDEAD_BEAA);

        do_access(1'b0, 4'h0, 32'h0000_0100, 32'd0);
        do_access(1'b1, 4'hF, 32'h0000_0100, 32'h5555_AAAA);
        do_access(1'b0, 4'h0, 32'h0000_0000, 32'd0);

        do_access(1'b1, 4'h0,    32'h0000_0010, 32'hFFFF_FFFF);
        do_access(1'b1, 4'b1100, 32'h0000_0017, 32'hA5A5_0000);
        do_access(1'b0, 4'h0,    32'h0000_0014, 32'd0);
        do_access(1'b0, 4'h0,    32'h0000_0012, 32'd0);

        for (int i = 0; i < 6; i++) begin
            do_access(1'b1, 4'($urandom_range(0, 15)), 32'($urandom_range(0, 7) * 4), $urandom);
            do_access(1'b0, 4'h0, 32'($urandom_range(0, 7) * 4), 32'd0);
        end

        // Reset during WAIT of a store must discard it.
        do_access(1'b1, 4'hF, 32'h0000_0020, 32'h1111_2222);
        @(negedge clk);
        req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h0000_0020; wdata = 32'h9999_9999;
        @(negedge clk);
        check_eq("busy_in_wait", 32'(busy), 32'd1);
        reset = 1'b0;
        req = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq("rstmid_ready", 32'(ready), 32'd0);
            check_eq("rstmid_busy", 32'(busy), 32'd0);
            check_eq("rstmid_err", 32'(err), 32'd0);
            @(negedge clk);
        end
        reset = 1'b1;
        do_access(1'b0, 4'h0, 32'h0000_0020, 32'd0);

        do_access(1'b1, 4'hF,    MMIO_BASE, 32'h1234_5678);
`ifdef MIPS_DMEM_MMIO_EN
        check_eq("mmio_store", mmio_out, 32'h1234_5678);
`endif
        do_access(1'b1, 4'b0010, MMIO_BASE, 32'h0000_AB00);
        do_access(1'b0, 4'h0,    MMIO_BASE, 32'd0);
`ifdef MIPS_DMEM_MMIO_EN
        check_eq("mmio_lane", mmio_out, 32'h1234_AB78);
`endif
        do_access(1'b0, 4'h0, 32'h0000_0000, 32'd0);

        // Zero-wait instance: req held high gives a completion every 3 cycles.
        @(negedge clk);
        req0 = 1'b1;
        pulses = 0; last = -1; first = -1; extra = 0;
        gap_ok = 1'b1; err_seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (ready0) begin
                if (first < 0) first = c;
                if (last >= 0 && (c - last) != 3) gap_ok = 1'b0;
                if (err0) err_seen = 1'b1;
                last = c;
                pulses++;
            end
        end
        req0 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ready0) extra++;
        end
        check_eq("ws0_pulses", 32'(pulses), 32'd4);
        check_eq("ws0_first", 32'(first), 32'd1);
        check_eq("ws0_gap", 32'(gap_ok), 32'd1);
        check_eq("ws0_err", 32'(err_seen), 32'd0);
        check_eq("ws0_extra", 32'(extra), 32'd0);

        repeat (4) @(negedge clk);
        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
